scm_3r2w_port_arbiter: RTL and testbench

Arbiter and sequencer placed in front of the 3-read/2-write byte-enabled latch register file. It shares the two write ports among `N_WR` write masters and the three read ports among `N_RD` read masters using round-robin arbitration. It resolves same-address write contention and read-during-write hazards, and it routes one-cycle-latency read data back to the requesting master. All SCM-side outputs connect directly to the register file's read/write port signals.

---
 rtl/scm_3r2w_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_scm_3r2w_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scm_3r2w_port_arbiter.sv
// Round-robin arbiter and sequencer for the 3-read/2-write byte-enabled latch register file.
// Define SCM_ARB_WRITE_MERGE_EN to allow a same-address write pair with disjoint byte enables in one cycle.
module scm_3r2w_port_arbiter #(
  parameter int N_WR       = 4,
  parameter int N_RD       = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_WR-1:0]            wr_req_i,
  input  logic [N_WR*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [N_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic [N_WR*NUM_BYTE-1:0]   wr_be_i,
  output logic [N_WR-1:0]            wr_gnt_o,
  input  logic [N_RD-1:0]            rd_req_i,
  input  logic [N_RD*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [N_RD-1:0]            rd_gnt_o,
  output logic [N_RD-1:0]            rd_rvalid_o,
  output logic [N_RD*DATA_WIDTH-1:0] rd_rdata_o,
  output logic [2:0]                 scm_re_o,
  output logic [3*ADDR_WIDTH-1:0]    scm_raddr_o,
  input  logic [3*DATA_WIDTH-1:0]    scm_rdata_i,
  output logic [1:0]                 scm_we_o,
  output logic [2*ADDR_WIDTH-1:0]    scm_waddr_o,
  output logic [2*DATA_WIDTH-1:0]    scm_wdata_o,
  output logic [2*NUM_BYTE-1:0]      scm_wbe_o
);

  localparam int WP_W = $clog2(N_WR);
  localparam int RP_W = $clog2(N_RD);

  function automatic int wrapAdd(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

  function automatic logic [WP_W-1:0] wrNext(input logic [WP_W-1:0] idx);
    return (idx == WP_W'(N_WR - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [RP_W-1:0] rdNext(input logic [RP_W-1:0] idx);
    return (idx == RP_W'(N_RD - 1)) ? '0 : idx + 1'b1;
  endfunction

  logic [WP_W-1:0]       wrPtr, wrPtrNxt;
  logic [RP_W-1:0]       rdPtr, rdPtrNxt;
  logic                  weA, weB;
  logic [WP_W-1:0]       wIdxA, wIdxB;
  logic [ADDR_WIDTH-1:0] wAddrA, wAddrB;
  logic [NUM_BYTE-1:0]   wBeA, wBeB;
  logic [N_WR-1:0]       wrGnt;
  logic [N_RD-1:0]       rdGnt;
  logic [2:0]            rVld_p0;
  logic [RP_W-1:0]       rOwner_p0 [3];
  logic [2:0]            rVld_p1;
  logic [RP_W-1:0]       rOwner_p1 [3];

  // Stage p0: write port selection and same-address contention
  always_comb begin
    logic foundA, foundB, wrConflict;
    int   idx;
    foundA     = 1'b0;
    foundB     = 1'b0;
    wrConflict = 1'b0;
    idx        = 0;
    wIdxA      = '0;
    wIdxB      = '0;
    for (int i = 0; i < N_WR; i++) begin
      idx = wrapAdd(int'(wrPtr), i, N_WR);
      if (wr_req_i[idx]) begin
        if (!foundA) begin
          foundA = 1'b1;
          wIdxA  = WP_W'(idx);
        end else if (!foundB) begin
          foundB = 1'b1;
          wIdxB  = WP_W'(idx);
        end
      end
    end
    wAddrA = wr_addr_i[int'(wIdxA)*ADDR_WIDTH +: ADDR_WIDTH];
    wAddrB = wr_addr_i[int'(wIdxB)*ADDR_WIDTH +: ADDR_WIDTH];
    wBeA   = wr_be_i[int'(wIdxA)*NUM_BYTE +: NUM_BYTE];
    wBeB   = wr_be_i[int'(wIdxB)*NUM_BYTE +: NUM_BYTE];
`ifdef SCM_ARB_WRITE_MERGE_EN
    wrConflict = (wAddrA == wAddrB) && ((wBeA & wBeB) != '0);
`else
    wrConflict = (wAddrA == wAddrB);
`endif
    weA   = foundA & rst_n;
    weB   = foundB & rst_n & ~wrConflict;
    wrGnt = '0;
    if (weA) wrGnt[wIdxA] = 1'b1;
    if (weB) wrGnt[wIdxB] = 1'b1;
    if (weB)      wrPtrNxt = wrNext(wIdxB);
    else if (weA) wrPtrNxt = wrNext(wIdxA);
    else          wrPtrNxt = wrPtr;
  end

  // Reads hitting an address written this cycle are skipped without using a port
  always_comb begin
    int                    idx;
    int                    nPort;
    logic [ADDR_WIDTH-1:0] a;
    logic                  hazard;
    idx      = 0;
    nPort    = 0;
    a        = '0;
    hazard   = 1'b0;
    rdGnt    = '0;
    rVld_p0  = '0;
    rdPtrNxt = rdPtr;
    for (int p = 0; p < 3; p++) rOwner_p0[p] = '0;
    for (int i = 0; i < N_RD; i++) begin
      idx    = wrapAdd(int'(rdPtr), i, N_RD);
      a      = rd_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
      hazard = (weA && (a == wAddrA)) || (weB && (a == wAddrB));
      if (rd_req_i[idx] && !hazard && rst_n && (nPort < 3)) begin
        rdGnt[idx]       = 1'b1;
        rVld_p0[nPort]   = 1'b1;
        rOwner_p0[nPort] = RP_W'(idx);
        rdPtrNxt         = rdNext(RP_W'(idx));
        nPort            = nPort + 1;
      end
    end
  end

  assign wr_gnt_o = wrGnt;
  assign rd_gnt_o = rdGnt;
  assign scm_we_o = {weB, weA};
  assign scm_re_o = rVld_p0;

  always_comb begin
    scm_waddr_o = '0;
    scm_wdata_o = '0;
    scm_wbe_o   = '0;
    scm_raddr_o = '0;
    if (weA) begin
      scm_waddr_o[0 +: ADDR_WIDTH] = wAddrA;
      scm_wdata_o[0 +: DATA_WIDTH] = wr_data_i[int'(wIdxA)*DATA_WIDTH +: DATA_WIDTH];
      scm_wbe_o[0 +: NUM_BYTE]     = wBeA;
    end
    if (weB) begin
      scm_waddr_o[ADDR_WIDTH +: ADDR_WIDTH] = wAddrB;
      scm_wdata_o[DATA_WIDTH +: DATA_WIDTH] = wr_data_i[int'(wIdxB)*DATA_WIDTH +: DATA_WIDTH];
      scm_wbe_o[NUM_BYTE +: NUM_BYTE]       = wBeB;
    end
    for (int p = 0; p < 3; p++) begin
      if (rVld_p0[p])
        scm_raddr_o[p*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr_i[int'(rOwner_p0[p])*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Stage p0 -> p1: pointers and per-port read ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      rVld_p1 <= '0;
      for (int p = 0; p < 3; p++) rOwner_p1[p] <= '0;
    end else begin
      wrPtr   <= wrPtrNxt;
      rdPtr   <= rdPtrNxt;
      rVld_p1 <= rVld_p0;
      for (int p = 0; p < 3; p++) rOwner_p1[p] <= rOwner_p0[p];
    end
  end

  // Stage p1: route returning SCM data to the owning master
  always_comb begin
    rd_rvalid_o = '0;
    rd_rdata_o  = '0;
    for (int p = 0; p < 3; p++) begin
      if (rVld_p1[p]) begin
        rd_rvalid_o[rOwner_p1[p]] = 1'b1;
        rd_rdata_o[int'(rOwner_p1[p])*DATA_WIDTH +: DATA_WIDTH] = scm_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_scm_3r2w_port_arbiter.sv
// Directed bench for scm_3r2w_port_arbiter with a byte-enabled register file model behind the SCM ports.
// Expectations follow SCM_ARB_WRITE_MERGE_EN when the macro is defined for the build.
module tb_scm_3r2w_port_arbiter;

  localparam int NW = 4, NR = 4, AW = 5, DW = 32, NB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NW-1:0]     wrReq;
  logic [NW*AW-1:0]  wrAddr;
  logic [NW*DW-1:0]  wrData;
  logic [NW*NB-1:0]  wrBe;
  logic [NW-1:0]     wrGnt;
  logic [NR-1:0]     rdReq;
  logic [NR*AW-1:0]  rdAddr;
  logic [NR-1:0]     rdGnt;
  logic [NR-1:0]     rvalid;
  logic [NR*DW-1:0]  rdata;
  logic [2:0]        scmRe;
  logic [3*AW-1:0]   scmRaddr;
  logic [3*DW-1:0]   scmRdata;
  logic [1:0]        scmWe;
  logic [2*AW-1:0]   scmWaddr;
  logic [2*DW-1:0]   scmWdata;
  logic [2*NB-1:0]   scmWbe;
  logic [DW-1:0]     mem [32];
  int                nCmp = 0;
  int                nErr = 0;

  scm_3r2w_port_arbiter #(
    .N_WR(NW), .N_RD(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wrReq), .wr_addr_i(wrAddr), .wr_data_i(wrData), .wr_be_i(wrBe), .wr_gnt_o(wrGnt),
    .rd_req_i(rdReq), .rd_addr_i(rdAddr), .rd_gnt_o(rdGnt),
    .rd_rvalid_o(rvalid), .rd_rdata_o(rdata),
    .scm_re_o(scmRe), .scm_raddr_o(scmRaddr), .scm_rdata_i(scmRdata),
    .scm_we_o(scmWe), .scm_waddr_o(scmWaddr), .scm_wdata_o(scmWdata), .scm_wbe_o(scmWbe)
  );

  always #5 clk = ~clk;

  // Register file model: byte-enabled writes, one-cycle registered reads
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (scmWe[p])
        for (int b = 0; b < NB; b++)
          if (scmWbe[p*NB+b]) mem[scmWaddr[p*AW +: AW]][b*8 +: 8] <= scmWdata[p*DW + b*8 +: 8];
    for (int p = 0; p < 3; p++)
      if (scmRe[p]) scmRdata[p*DW +: DW] <= mem[scmRaddr[p*AW +: AW]];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setWr(input int m, input logic req, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NB-1:0] be);
    wrReq[m]           = req;
    wrAddr[m*AW +: AW] = a;
    wrData[m*DW +: DW] = d;
    wrBe[m*NB +: NB]   = be;
  endtask

  task automatic setRd(input int m, input logic req, input logic [AW-1:0] a);
    rdReq[m]           = req;
    rdAddr[m*AW +: AW] = a;
  endtask

  initial begin
    rst_n    = 1'b0;
    wrReq    = '0; wrAddr = '0; wrData = '0; wrBe = '0;
    rdReq    = '0; rdAddr = '0;
    scmRdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Requests during reset must see no grants or SCM activity
    @(negedge clk);
    wrReq = 4'hF; rdReq = 4'hF;
    #1;
    chk("rst_wr_gnt", wrGnt, 0);
    chk("rst_rd_gnt", rdGnt, 0);
    chk("rst_scm_we", scmWe, 0);
    chk("rst_scm_re", scmRe, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    wrReq = '0; rdReq = '0;
    rst_n = 1'b1;

    // C1..C3: four writers, distinct addresses, rotation {0,1},{2,3},{0,1}
    @(negedge clk);
    for (int m = 0; m < NW; m++) setWr(m, 1'b1, AW'(10 + m), 32'h1000_0000 + m, 4'hF);
    #1;
    chk("c1_wr_gnt", wrGnt, 4'b0011);
    chk("c1_scm_we", scmWe, 2'b11);
    chk("c1_waddr", scmWaddr, {5'd11, 5'd10});
    chk("c1_wdata", scmWdata, {32'h1000_0001, 32'h1000_0000});
    chk("c1_wbe", scmWbe, 8'hFF);
    chk("c1_rd_gnt", rdGnt, 0);
    @(negedge clk); #1;
    chk("c2_wr_gnt", wrGnt, 4'b1100);
    chk("c2_waddr", scmWaddr, {5'd13, 5'd12});
    @(negedge clk); #1;
    chk("c3_wr_gnt", wrGnt, 4'b0011);

    // C4..C6: four readers continuously, three grants per cycle rotating
    @(negedge clk);
    wrReq = '0;
    for (int m = 0; m < NR; m++) setRd(m, 1'b1, AW'(10 + m));
    #1;
    chk("c4_rd_gnt", rdGnt, 4'b0111);
    chk("c4_scm_re", scmRe, 3'b111);
    chk("c4_raddr", scmRaddr, {5'd12, 5'd11, 5'd10});
    chk("c4_wr_gnt", wrGnt, 0);
    @(negedge clk); #1;
    chk("c5_rd_gnt", rdGnt, 4'b1011);
    chk("c5_raddr", scmRaddr, {5'd11, 5'd10, 5'd13});
    chk("c5_rvalid", rvalid, 4'b0111);
    chk("c5_rdata", rdata, {32'h0, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});
    @(negedge clk); #1;
    chk("c6_rd_gnt", rdGnt, 4'b1101);
    chk("c6_rvalid", rvalid, 4'b1011);
    chk("c6_rdata", rdata, {32'h1000_0003, 32'h0, 32'h1000_0001, 32'h1000_0000});

    // C7: reads stop; a write with empty byte enables is still granted
    @(negedge clk);
    rdReq = '0;
    setWr(3, 1'b1, 5'd20, 32'hFFFF_FFFF, 4'h0);
    #1;
    chk("c7_rd_gnt", rdGnt, 0);
    chk("c7_rvalid", rvalid, 4'b1101);
    chk("c7_rdata", rdata, {32'h1000_0003, 32'h1000_0002, 32'h0, 32'h1000_0000});
    chk("c7_wr_gnt", wrGnt, 4'b1000);
    chk("c7_scm_we", scmWe, 2'b01);
    chk("c7_wbe", scmWbe, 8'h00);
    chk("c7_waddr", scmWaddr, {5'd0, 5'd20});

    // C8: same-address write pair with disjoint byte enables
    @(negedge clk);
    wrReq = '0;
    setWr(0, 1'b1, 5'd5, 32'h1122_3344, 4'b0011);
    setWr(1, 1'b1, 5'd5, 32'h5566_7788, 4'b1100);
    #1;
    chk("c8_rvalid", rvalid, 0);
`ifdef SCM_ARB_WRITE_MERGE_EN
    chk("c8_wr_gnt", wrGnt, 4'b0011);
    chk("c8_scm_we", scmWe, 2'b11);
    chk("c8_wbe", scmWbe, 8'hC3);
`else
    chk("c8_wr_gnt", wrGnt, 4'b0001);
    chk("c8_scm_we", scmWe, 2'b01);
    chk("c8_wbe", scmWbe, 8'h03);
    chk("c8_waddr", scmWaddr, {5'd0, 5'd5});
    @(negedge clk);
    wrReq[0] = 1'b0;
    #1;
    chk("c9_wr_gnt", wrGnt, 4'b0010);
    chk("c9_wbe", scmWbe, 8'h0C);
    chk("c9_waddr", scmWaddr, {5'd0, 5'd5});
`endif

    // C10: read back the merged word
    @(negedge clk);
    wrReq = '0;
    setRd(0, 1'b1, 5'd5);
    #1;
    chk("c10_rd_gnt", rdGnt, 4'b0001);
    chk("c10_raddr", scmRaddr, {5'd0, 5'd0, 5'd5});

    // C11: read-during-write on address 3 is withheld, a later reader still gets a port
    @(negedge clk);
    setWr(2, 1'b1, 5'd3, 32'hDEAD_BEEF, 4'hF);
    setRd(1, 1'b1, 5'd3);
    setRd(0, 1'b1, 5'd10);
    #1;
    chk("c11_rvalid", rvalid, 4'b0001);
    chk("c11_rdata", rdata, {96'h0, 32'h5566_3344});
    chk("c11_wr_gnt", wrGnt, 4'b0100);
    chk("c11_waddr", scmWaddr, {5'd0, 5'd3});
    chk("c11_rd_gnt", rdGnt, 4'b0001);
    chk("c11_scm_re", scmRe, 3'b001);
    chk("c11_raddr", scmRaddr, {5'd0, 5'd0, 5'd10});

    // C12: stalled read proceeds one cycle later
    @(negedge clk);
    wrReq = '0;
    rdReq[0] = 1'b0;
    #1;
    chk("c12_rd_gnt", rdGnt, 4'b0010);
    chk("c12_raddr", scmRaddr, {5'd0, 5'd0, 5'd3});
    chk("c12_rvalid", rvalid, 4'b0001);
    chk("c12_rdata", rdata, {96'h0, 32'h1000_0000});

    // C13: new data arrives two cycles after the original request; then reset hits an in-flight read
    @(negedge clk);
    rdReq = '0;
    setRd(2, 1'b1, 5'd11);
    #1;
    chk("c13_rvalid", rvalid, 4'b0010);
    chk("c13_rdata", rdata, {64'h0, 32'hDEAD_BEEF, 32'h0});
    chk("c13_rd_gnt", rdGnt, 4'b0100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rdReq = '0;
    #1;
    chk("rst2_rvalid", rvalid, 0);
    chk("rst2_rdata", rdata, 0);
    @(negedge clk); #1;
    chk("rst2_rvalid_hold", rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // C14: pointers back at zero after reset
    @(negedge clk);
    for (int m = 0; m < NW; m++) setWr(m, 1'b1, AW'(10 + m), 32'h2000_0000 + m, 4'hF);
    for (int m = 0; m < NR; m++) setRd(m, 1'b1, AW'(20 + m));
    #1;
    chk("c14_wr_gnt", wrGnt, 4'b0011);
    chk("c14_rd_gnt", rdGnt, 4'b0111);
    chk("c14_rvalid", rvalid, 0);
    @(negedge clk);
    wrReq = '0; rdReq = '0;
    #1;
    chk("c15_rvalid", rvalid, 4'b0111);
    chk("c15_rdata", rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
